// File: rtl/conc_stim_player.sv
// Vector-playback sequencer: plays {obs, data} words from an internal RAM into a DUT,
// one vector per clock, one-shot or looped, with stall, abort and a start/done handshake.
module conc_stim_player #(
    parameter int DATA_W = 31,
    parameter int OBS_W  = 1,
    parameter int DEPTH  = 31,
    parameter int ADDR_W = 5,
    parameter int REP_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ld_en,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [OBS_W+DATA_W-1:0] ld_data,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_W:0]         len,
    input  logic [REP_W-1:0]        reps,
    input  logic                    stall,
    input  logic                    abort,
    output logic [DATA_W-1:0]       data_o,
    output logic [OBS_W-1:0]        obs_o,
    output logic                    valid,
    output logic [ADDR_W-1:0]       vec_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int WORD_W = OBS_W + DATA_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  reps_l;
    logic [ADDR_W:0]   len_l;
    logic              mode_l;
    logic              err_pend;

    logic addr_ok;
    logic len_ok;
    logic write_en;
    logic last_vec;
    logic last_pass;
    logic err_req;
    logic done_next;

    always_comb begin
        addr_ok   = ({1'b0, ld_addr} < DEPTH_L);
        len_ok    = (len != '0) && (len <= DEPTH_L);
        write_en  = ld_en && (state == ST_IDLE) && addr_ok;
        last_vec  = ({1'b0, pc} == (len_l - (ADDR_W+1)'(1)));
        last_pass = !mode_l || ((reps_l != '0) && (rep_cnt == (reps_l - REP_W'(1))));
        err_req   = ((state == ST_IDLE) && ld_en && !addr_ok)
                  || ((state == ST_IDLE) && start && !len_ok)
                  || ((state != ST_IDLE) && ld_en);
        done_next = (state == ST_FIN) && !abort;
    end

    assign busy = (state != ST_IDLE);

    // RAM is deliberately outside the reset domain so a reset never loses loaded vectors.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            rep_cnt  <= '0;
            reps_l   <= '0;
            len_l    <= '0;
            mode_l   <= 1'b0;
            err_pend <= 1'b0;
            data_o   <= '0;
            obs_o    <= '0;
            valid    <= 1'b0;
            vec_idx  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // An error raised on the completion edge is held back one cycle so err never overlaps done.
            if (done_next) begin
                err_pend <= err_req || err_pend;
            end else begin
                err      <= err_req || err_pend;
                err_pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start && len_ok) begin
                        mode_l  <= mode;
                        len_l   <= len;
                        reps_l  <= reps;
                        pc      <= '0;
                        rep_cnt <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        data_o  <= '0;
                        obs_o   <= '0;
                        valid   <= 1'b0;
                        vec_idx <= '0;
                        state   <= ST_IDLE;
                    end else if (!stall) begin
                        {obs_o, data_o} <= mem[pc];
                        vec_idx         <= pc;
                        valid           <= 1'b1;
                        if (last_vec) begin
                            if (last_pass) begin
                                state <= ST_FIN;
                            end else begin
                                pc <= '0;
                                if (rep_cnt != '1) begin
                                    rep_cnt <= rep_cnt + REP_W'(1);
                                end
                            end
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    data_o  <= '0;
                    obs_o   <= '0;
                    valid   <= 1'b0;
                    vec_idx <= '0;
                    done    <= !abort;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conc_stim_player.sv
// Directed bench for conc_stim_player: hand-computed vector streams, handshakes and error pulses,
// checked with immediate assertions after each clock edge.
module tb_conc_stim_player;

    localparam int DATA_W = 31;
    localparam int OBS_W  = 1;
    localparam int DEPTH  = 31;
    localparam int ADDR_W = 5;
    localparam int REP_W  = 8;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    ld_en;
    logic [ADDR_W-1:0]       ld_addr;
    logic [OBS_W+DATA_W-1:0] ld_data;
    logic                    start;
    logic                    mode;
    logic [ADDR_W:0]         len;
    logic [REP_W-1:0]        reps;
    logic                    stall;
    logic                    abort;
    logic [DATA_W-1:0]       data_o;
    logic [OBS_W-1:0]        obs_o;
    logic                    valid;
    logic [ADDR_W-1:0]       vec_idx;
    logic                    busy;
    logic                    done;
    logic                    err;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] exp_data [5] = '{31'h11, 31'h22, 31'h33, 31'h44, 31'h66};
    logic              exp_obs  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    conc_stim_player #(
        .DATA_W(DATA_W), .OBS_W(OBS_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .REP_W(REP_W)
    ) dut (
        .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .mode(mode), .len(len), .reps(reps), .stall(stall), .abort(abort),
        .data_o(data_o), .obs_o(obs_o), .valid(valid), .vec_idx(vec_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_vec(input string tag, input int i);
        check_output({tag, " data"}, 64'(data_o), 64'(exp_data[i]));
        check_output({tag, " obs"}, 64'(obs_o), 64'(exp_obs[i]));
        check_output({tag, " idx"}, 64'(vec_idx), 64'(i));
        check_output({tag, " valid"}, 64'(valid), 64'd1);
    endtask

    task automatic check_idle(input string tag, input logic want_done);
        check_output({tag, " valid"}, 64'(valid), 64'd0);
        check_output({tag, " data"}, 64'(data_o), 64'd0);
        check_output({tag, " done"}, 64'(done), 64'(want_done));
        check_output({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [OBS_W+DATA_W-1:0] w);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = w;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic apply_stimulus(input logic m, input logic [ADDR_W:0] l, input logic [REP_W-1:0] r);
        start = 1'b1;
        mode  = m;
        len   = l;
        reps  = r;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        mode = 1'b0; len = '0; reps = '0; stall = 1'b0; abort = 1'b0;
        step();
        step();
        check_idle("reset", 1'b0);
        check_output("reset err", 64'(err), 64'd0);
        check_output("reset idx", 64'(vec_idx), 64'd0);
        reset = 1'b1;

        $display("[TB] one-shot playback");
        load(5'd0, {1'b1, 31'h11});
        load(5'd1, {1'b0, 31'h22});
        load(5'd2, {1'b1, 31'h33});
        load(5'd3, {1'b0, 31'h44});
        apply_stimulus(1'b0, 6'd4, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_vec("oneshot", i);
            check_output("oneshot busy", 64'(busy), 64'd1);
        end
        step();
        check_idle("oneshot fin", 1'b1);
        step();
        check_idle("oneshot after", 1'b0);

        $display("[TB] loop with repeat count");
        apply_stimulus(1'b1, 6'd2, 8'd3);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 2; i++) begin
                step();
                check_vec("loop", i);
            end
        end
        step();
        check_idle("loop fin", 1'b1);

        $display("[TB] stall");
        apply_stimulus(1'b0, 6'd4, 8'd0);
        step();
        check_vec("stall v0", 0);
        step();
        check_vec("stall v1", 1);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            check_vec("stall hold", 1);
        end
        stall = 1'b0;
        step();
        check_vec("stall v2", 2);
        step();
        check_vec("stall v3", 3);
        step();
        check_idle("stall fin", 1'b1);

        $display("[TB] abort in infinite loop");
        apply_stimulus(1'b1, 6'd3, 8'd0);
        for (int s = 1; s <= 14; s++) begin
            step();
            check_output("abort run idx", 64'(vec_idx), 64'((s - 1) % 3));
        end
        check_vec("abort point", 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort", 1'b0);
        step();
        check_output("abort no done", 64'(done), 64'd0);
        apply_stimulus(1'b0, 6'd2, 8'd0);
        step();
        check_vec("restart v0", 0);
        step();
        check_vec("restart v1", 1);
        step();
        check_idle("restart fin", 1'b1);

        $display("[TB] illegal requests");
        apply_stimulus(1'b0, 6'd0, 8'd0);
        check_output("len0 err", 64'(err), 64'd1);
        check_output("len0 busy", 64'(busy), 64'd0);
        step();
        check_output("len0 err clear", 64'(err), 64'd0);
        apply_stimulus(1'b0, 6'd32, 8'd0);
        check_output("len32 err", 64'(err), 64'd1);
        check_output("len32 busy", 64'(busy), 64'd0);
        step();
        load(5'd31, {1'b1, 31'h7EAD});
        check_output("addr31 err", 64'(err), 64'd1);
        step();
        check_output("addr31 err clear", 64'(err), 64'd0);

        apply_stimulus(1'b0, 6'd4, 8'd0);
        step();
        check_vec("ldrun v0", 0);
        ld_en = 1'b1; ld_addr = 5'd1; ld_data = {1'b1, 31'h55};
        step();
        ld_en = 1'b0;
        check_vec("ldrun v1", 1);
        check_output("ldrun err", 64'(err), 64'd1);
        step();
        check_vec("ldrun v2", 2);
        check_output("ldrun err clear", 64'(err), 64'd0);
        step();
        check_vec("ldrun v3", 3);
        step();
        check_idle("ldrun fin", 1'b1);
        check_output("ldrun fin err", 64'(err), 64'd0);

        $display("[TB] load and start together");
        ld_en = 1'b1; ld_addr = 5'd4; ld_data = {1'b0, 31'h66};
        apply_stimulus(1'b0, 6'd5, 8'd0);
        ld_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_vec("ldstart", i);
        end
        step();
        check_idle("ldstart fin", 1'b1);

        $display("[TB] reset mid-run");
        apply_stimulus(1'b0, 6'd4, 8'd0);
        step();
        step();
        step();
        check_vec("rst v2", 2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_idle("rst mid", 1'b0);
        check_output("rst idx", 64'(vec_idx), 64'd0);
        check_output("rst obs", 64'(obs_o), 64'd0);
        apply_stimulus(1'b0, 6'd4, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_vec("rst replay", i);
        end
        step();
        check_idle("rst replay fin", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conc_stim_player.md
Name: conc_stim_player

Overview:
- Synthesizable, parametrised vector-playback sequencer that drives a DUT's data input and observation strobe, one vector per clock.
- Vectors live in an internal RAM that is loaded over a write port. Playback runs one-shot or looped, with a repeat count, stall, abort and a start/done handshake.
- Sits between the bench/control logic and the DUT top. It drives the DUT data-in bus and the __obs strobe.

Parameters:
- DATA_W, 31, width of the data vector driven to the DUT.
- OBS_W, 1, width of the observation field; vector word = {obs, data}.
- DEPTH, 31, number of vector entries in RAM.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH.
- REP_W, 8, width of the repeat counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ld_en  in  1  RAM write strobe.
- ld_addr  in  ADDR_W  RAM write address.
- ld_data  in  OBS_W+DATA_W  RAM write word, obs in the MSBs.
- start  in  1  start playback; sampled only in IDLE.
- mode  in  1  0 = one-shot, 1 = loop; latched at start.
- len  in  ADDR_W+1  number of vectors per pass, valid range 1..DEPTH; latched at start.
- reps  in  REP_W  loop passes; 0 = infinite; ignored in one-shot; latched at start.
- stall  in  1  freeze playback.
- abort  in  1  terminate playback.
- data_o  out  DATA_W  vector data to the DUT.
- obs_o  out  OBS_W  observation strobe to the DUT.
- valid  out  1  data_o/obs_o carry a vector.
- vec_idx  out  ADDR_W  index of the vector currently on data_o.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (reset=0 at an edge):
  - state goes to IDLE.
  - All outputs are 0, and pc, rep_cnt and the latched fields are 0.
  - RAM contents are not cleared.
  - Reset mid-playback has the same effect.
- States: IDLE, RUN, FIN.
- IDLE:
  - ld_en=1 writes ld_data to RAM[ld_addr] at the edge.
  - ld_addr >= DEPTH: write dropped, err pulses.
  - start=1 with len==0 or len>DEPTH: err pulses, stay IDLE.
  - Legal start at edge k: latch mode, len and reps; pc=0; rep_cnt=0; go to RUN.
  - ld_en and start in the same cycle: the write completes first, so the new word is playable.
- RUN, per edge with stall=0:
  - {obs_o,data_o} <= RAM[pc]; vec_idx <= pc; valid <= 1.
  - Vector 0 appears after edge k+1; vector i appears after edge k+1+i (1-cycle start latency, then 1 vector/clock).
  - pc==len-1, one-shot, or loop with reps!=0 and rep_cnt==reps-1: go to FIN.
  - pc==len-1 in any other loop case: pc wraps to 0, rep_cnt increments, no bubble.
  - rep_cnt saturates at all-ones when reps==0.
- RUN with stall=1: pc, rep_cnt, outputs and valid all hold (valid stays 1 if already 1). A stall at the edge after start delays vector 0.
- FIN (one cycle):
  - Outputs go to 0, valid=0, done=1 for exactly one cycle, then IDLE.
  - busy=1 from the edge after start through FIN.
- abort=1 in RUN or FIN (priority over stall and completion):
  - Next edge: IDLE, outputs 0, valid 0, done stays 0.
  - abort in IDLE has no effect.
- ld_en in RUN/FIN: write ignored, err pulses. Playback is unaffected.
- start while busy: ignored, no err.
- Width rules:
  - pc and vec_idx are ADDR_W bits.
  - len compare is done at ADDR_W+1 bits.
  - rep_cnt is REP_W bits; compare against reps-1 only when reps!=0.
- err and done never assert in the same cycle. err is registered: it asserts the cycle after the offending edge.

Test Plan:
- Load, one-shot: load RAM[0..3]={1,0x11},{0,0x22},{1,0x33},{0,0x44}; start, mode=0, len=4 at edge k.
  - Edges k+1..k+4: data_o=0x11,0x22,0x33,0x44; obs_o=1,0,1,0; vec_idx=0..3; valid=1.
  - Edge k+5: valid=0, done=1. Edge k+6: busy=0.
- Loop, repeat count: same RAM, mode=1, len=2, reps=3.
  - data_o sequence 0x11,0x22 ×3 with no gap, then done. Exactly 6 valid cycles.
- Stall: one-shot, len=4, stall=1 on the cycle after vector 1 is presented, for 3 cycles.
  - 0x22 is held 4 cycles total, then 0x33, 0x44.
  - 7 valid cycles, done on the 8th.
- Abort in loop: mode=1, reps=0, abort at vector index 1 of pass 5.
  - Next edge: valid=0, busy=0, done=0.
  - A restart replays from vector 0.
- Illegal requests:
  - start with len=0 → err pulse, busy=0.
  - start with len=32 (DEPTH=31) → err pulse, busy=0.
  - ld_en with ld_addr=31 → err pulse, RAM unchanged.
  - ld_en during RUN → err pulse, output stream unchanged.
- Reset mid-run: reset=0 for one edge during vector 2.
  - All outputs 0, state IDLE.
  - Previously loaded RAM still plays correctly after a new start.
